seq1001_tx: RTL and testbench



---
 rtl/seq1001_tx.sv | 69 ++++++
 tb/tb_seq1001_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq1001_tx.sv
// seq1001_tx: MSB-first serial word transmitter with a shadow overlapping-1001 counter.
// Define SEQ1001_TX_B2B_EN to accept the next word on the last-bit cycle (gapless streaming).
module seq1001_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             x_valid,
  output logic             ready,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  localparam int BW = $clog2(WIDTH);
  logic [1:0] state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0] bitcnt;
  logic [2:0] hist;
  logic last, accept;
  assign last = state == SHIFT && bitcnt == '0;
  assign accept = load & ready;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (load ? SHIFT : IDLE) :
              state == SHIFT ? (last && !accept ? DONE : SHIFT) : IDLE;
`ifdef SEQ1001_TX_B2B_EN
  logic b2b_done;
  always_ff @(posedge clk)
    if (reset) b2b_done <= 1'b0;
    else b2b_done <= last & load;
  always_comb begin
    x_valid = state == SHIFT;
    x = x_valid & shreg[WIDTH-1];
    ready = state == IDLE || last;
    done = state == DONE || b2b_done;
  end
`else
  always_comb begin
    x_valid = state == SHIFT;
    x = x_valid & shreg[WIDTH-1];
    ready = state == IDLE;
    done = state == DONE;
  end
`endif
  // history only advances on emitted bits, so a match never spans two words
  always_ff @(posedge clk)
    if (reset) begin
      shreg <= '0;
      bitcnt <= '0;
      hist <= '0;
      match_cnt <= '0;
    end else if (accept) begin
      shreg <= data;
      bitcnt <= BW'(WIDTH - 1);
      hist <= '0;
      match_cnt <= '0;
    end else if (x_valid) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      bitcnt <= bitcnt - BW'(1);
      hist <= {hist[1:0], x};
      if ({hist, x} == 4'b1001 && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_seq1001_tx.sv
// tb_seq1001_tx: directed bench with a per-cycle phase model for two instances (8/4 and 16/2).
module tb_seq1001_tx;
  logic clk = 0, reset = 1;
  logic [1:0] load = '0;
  logic [31:0] data_i [2];
  logic [1:0] x, xv, rdy, dn;
  logic [3:0] mc_a;
  logic [1:0] mc_b;
  int tests = 0, fails = 0;
  int wid[2] = '{8, 16};
  int cmax[2] = '{15, 3};
  int ph[2], nem[2];
  logic [31:0] wd[2];
  logic bd[2];
  logic armed = 0;
  always #5 clk = ~clk;
  seq1001_tx #(.WIDTH(8), .CNT_W(4)) u_a (.clk(clk), .reset(reset), .load(load[0]), .data(data_i[0][7:0]),
    .x(x[0]), .x_valid(xv[0]), .ready(rdy[0]), .done(dn[0]), .match_cnt(mc_a));
  seq1001_tx #(.WIDTH(16), .CNT_W(2)) u_b (.clk(clk), .reset(reset), .load(load[1]), .data(data_i[1][15:0]),
    .x(x[1]), .x_valid(xv[1]), .ready(rdy[1]), .done(dn[1]), .match_cnt(mc_b));
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // 1001 occurrences among the first n bits of w, read MSB first, saturated at cm
  function automatic int c1001(logic [31:0] w, int width, int n, int cm);
    int c = 0;
    for (int j = 3; j < n; j++)
      if ({w[width+2-j], w[width+1-j], w[width-j], w[width-1-j]} == 4'b1001) c++;
    return c > cm ? cm : c;
  endfunction
  function automatic logic exp_ready(int i);
`ifdef SEQ1001_TX_B2B_EN
    return ph[i] == 0 || ph[i] == wid[i];
`else
    return ph[i] == 0;
`endif
  endfunction
  // ph: 0 idle, 1..W bit number on the line, W+1 done cycle; nem counts bits already emitted
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (reset) begin
        ph[i] = 0; nem[i] = 0; wd[i] = 0; bd[i] = 0; armed = 1;
      end else begin
        logic acc;
        acc = load[i] && exp_ready(i);
        bd[i] = acc && ph[i] == wid[i];
        if (acc) begin
          ph[i] = 1; nem[i] = 0; wd[i] = data_i[i];
        end else if (ph[i] > 0) begin
          if (ph[i] <= wid[i]) nem[i]++;
          ph[i] = ph[i] == wid[i] + 1 ? 0 : ph[i] + 1;
        end
      end
  always @(negedge clk)
    if (armed)
      for (int i = 0; i < 2; i++) begin
        logic ev;
        ev = ph[i] >= 1 && ph[i] <= wid[i];
        check($sformatf("x_valid[%0d]", i), xv[i], ev);
        check($sformatf("x[%0d]", i), x[i], ev ? wd[i][wid[i]-ph[i]] : 1'b0);
        check($sformatf("ready[%0d]", i), rdy[i], exp_ready(i));
        check($sformatf("done[%0d]", i), dn[i], ph[i] == wid[i] + 1 || bd[i]);
        check($sformatf("match_cnt[%0d]", i), i ? {2'b0, mc_b} : mc_a, c1001(wd[i], wid[i], nem[i], cmax[i]));
      end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(int i, logic [31:0] d);
    @(negedge clk);
    load[i] = 1; data_i[i] = d;
    @(negedge clk);
    load[i] = 0;
  endtask
  task automatic wait_done(int i, string name, int exp_mc);
    for (int c = 0; c < 60 && !dn[i]; c++) @(negedge clk);
    check({name, "_done_seen"}, dn[i], 1);
    check({name, "_mc"}, i ? {2'b0, mc_b} : mc_a, exp_mc);
  endtask
  initial begin
    logic [7:0] got;
    data_i[0] = 0; data_i[1] = 0;
    tick(2);
    reset = 0;
    tick();
    check("rst_ready", rdy[0], 1);
    check("rst_xv", xv[0], 0);
    check("rst_x", x[0], 0);
    check("rst_done", dn[0], 0);
    check("rst_mc", mc_a, 0);
    send(0, 8'b1001_0010);
    got = 0;
    for (int j = 0; j < 8; j++) begin
      got = {got[6:0], x[0]};
      if (j < 7) tick();
    end
    check("seq_92", got, 8'b1001_0010);
    tick();
    check("done_k9", dn[0], 1);
    wait_done(0, "w92", 2);
    tick();
    check("ready_k10", rdy[0], 1);
    send(0, 8'hFF);
    wait_done(0, "wFF", 0);
    send(0, 8'h99);
    wait_done(0, "w99", 2);
    send(0, 8'h90);
    tick(2);
    load[0] = 1; data_i[0] = 8'h00;
    tick();
    load[0] = 0;
    wait_done(0, "w90", 1);
    send(0, 8'hFF);
    tick(3);
    reset = 1;
    tick();
    reset = 0;
    check("midrst_ready", rdy[0], 1);
    check("midrst_mc", mc_a, 0);
    check("midrst_done", dn[0], 0);
    tick(12);
    send(1, 32'h0000_9249);
    wait_done(1, "w9249", 3);
`ifdef SEQ1001_TX_B2B_EN
    tick(2);
    begin
      int run = 0;
      send(1, 32'h0000_9249);
      for (int c = 0; c < 40; c++) begin
        if (xv[1]) run++;
        if (c == 15) begin load[1] = 1; data_i[1] = 32'h0000_9249; end
        if (c == 16) load[1] = 0;
        tick();
      end
      check("b2b_valid_run", run, 32);
    end
`endif
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
